// File: rtl/vmac_pkg.sv
// Shared types for the vector multiply-add pipeline: operation and element
// width encodings plus the element-width helper.
package vmac_pkg;

  localparam int LANE_W = 32;

  // [2]=0: vd = +/-(A*B)+C ; [2]=1: vd = +/-(A*C)+B ; [1] negates ; [0] .vx
  typedef enum logic [2:0] {
    VMACC_VV  = 3'b000,
    VMACC_VX  = 3'b001,
    VNMSAC_VV = 3'b010,
    VNMSAC_VX = 3'b011,
    VMADD_VV  = 3'b100,
    VMADD_VX  = 3'b101,
    VNMSUB_VV = 3'b110,
    VNMSUB_VX = 3'b111
  } accum_op_e;

  typedef enum logic [1:0] {
    SEW8        = 2'b00,
    SEW16       = 2'b01,
    SEW32       = 2'b10,
    SEW_ILLEGAL = 2'b11
  } sew_e;

  // Element width in bits; zero marks the illegal encoding.
  function automatic logic [5:0] sew_bits(sew_e s);
    case (s)
      SEW8:    return 6'd8;
      SEW16:   return 6'd16;
      SEW32:   return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/vector_mac_pipeline_if.sv
// Operand/result bundle of the vector multiply-add pipeline.
// The vm and mask_v0 signals exist only when VMAC_MASK_EN is defined.
interface vector_mac_pipeline_if #(
  parameter int VLEN = 512,
  parameter int VL_W = $clog2(VLEN/8) + 1
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        accum_op;
  logic [1:0]        sew;
  logic [VL_W-1:0]   vl;
  logic [VLEN-1:0]   data_A;
  logic [31:0]       scalar_rs1;
  logic [VLEN-1:0]   data_B;
  logic [VLEN-1:0]   data_C;
`ifdef VMAC_MASK_EN
  logic              vm;
  logic [VLEN/8-1:0] mask_v0;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   out_data;
  logic              out_illegal;

  modport master (
    output in_valid, accum_op, sew, vl, data_A, scalar_rs1, data_B, data_C,
`ifdef VMAC_MASK_EN
    output vm, mask_v0,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, out_illegal
  );

  modport slave (
    input  in_valid, accum_op, sew, vl, data_A, scalar_rs1, data_B, data_C,
`ifdef VMAC_MASK_EN
    input  vm, mask_v0,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, out_illegal
  );

endinterface

// File: rtl/vmac_lane.sv
// One 32-bit slice of the multiply-add datapath: 4x8 / 2x16 / 1x32
// multiply-low (S2), then negate/add and merge with old vd (S3).
module vmac_lane
  import vmac_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  sew_e        sew,
  input  logic [31:0] mul_a,
  input  logic [31:0] mul_b,
  input  logic [31:0] addend,
  input  logic [31:0] old_vd,
  input  logic [3:0]  byte_act,
  input  logic        neg,
  output logic [31:0] result
);

  // Low SEW bits of each element product; signedness does not affect them.
  function automatic logic [31:0] mul_low(sew_e s, logic [31:0] a, logic [31:0] b);
    logic [31:0] p;
    p = '0;
    case (s)
      SEW8:    for (int k = 0; k < 4; k++) p[8*k +: 8] = a[8*k +: 8] * b[8*k +: 8];
      SEW16:   for (int k = 0; k < 2; k++) p[16*k +: 16] = a[16*k +: 16] * b[16*k +: 16];
      SEW32:   p = a * b;
      default: p = '0;
    endcase
    return p;
  endfunction

  // Per-element addend +/- product, wrapping modulo 2^SEW.
  function automatic logic [31:0] add_neg(sew_e s, logic [31:0] acc, logic [31:0] prod, logic n);
    logic [31:0] r;
    r = acc;
    case (s)
      SEW8:    for (int k = 0; k < 4; k++)
                 r[8*k +: 8] = n ? acc[8*k +: 8] - prod[8*k +: 8] : acc[8*k +: 8] + prod[8*k +: 8];
      SEW16:   for (int k = 0; k < 2; k++)
                 r[16*k +: 16] = n ? acc[16*k +: 16] - prod[16*k +: 16] : acc[16*k +: 16] + prod[16*k +: 16];
      SEW32:   r = n ? acc - prod : acc + prod;
      default: r = acc;
    endcase
    return r;
  endfunction

  // Inactive bytes keep the old destination value (undisturbed).
  function automatic logic [31:0] merge(logic [3:0] act, logic [31:0] res, logic [31:0] old);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = act[k] ? res[8*k +: 8] : old[8*k +: 8];
    return m;
  endfunction

  logic [31:0] prod_p2;
  logic [31:0] addend_p2;
  logic [31:0] old_p2;
  logic [3:0]  act_p2;
  logic        neg_p2;
  sew_e        sew_p2;
  logic [31:0] result_p3;

  // ---- S2: register lane products alongside the operands still needed ----
  always_ff @(posedge clk) begin
    if (en) begin
      prod_p2   <= mul_low(sew, mul_a, mul_b);
      addend_p2 <= addend;
      old_p2    <= old_vd;
      act_p2    <= byte_act;
      neg_p2    <= neg;
      sew_p2    <= sew;
    end
  end

  // ---- S3: negate/add and merge with old vd into the visible result ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_p3 <= '0;
    end else if (en) begin
      result_p3 <= merge(act_p2, add_neg(sew_p2, addend_p2, prod_p2, neg_p2), old_p2);
    end
  end

  assign result = result_p3;

endmodule

// File: rtl/vector_mac_pipeline.sv
// Three-stage vector integer multiply-add (vmacc/vnmsac/vmadd/vnmsub,
// .vv/.vx) over a VLEN-bit group at SEW 8/16/32 with tail handling and a
// single global advance enable for backpressure.
// Optional v0 masking is compiled in with VMAC_MASK_EN.
module vector_mac_pipeline
  import vmac_pkg::*;
#(
  parameter int VLEN = 512,
  parameter int VL_W = $clog2(VLEN/8) + 1
)(
  input logic                  clk,
  input logic                  reset,
  vector_mac_pipeline_if.slave bus
);

  localparam int NB = VLEN / 8;
  localparam int NL = VLEN / LANE_W;

  sew_e            sew_in;
  logic            legal;
  logic            adv;
  logic [VLEN-1:0] bcast;
  logic [VLEN-1:0] mul_a_in;
  logic [VLEN-1:0] mul_b_in;
  logic [VLEN-1:0] addend_in;
  logic [NB-1:0]   act8;
  logic [NB-1:0]   act16;
  logic [NB-1:0]   act32;
  logic [NB-1:0]   act_in;

  logic [VLEN-1:0] mul_a_p1;
  logic [VLEN-1:0] mul_b_p1;
  logic [VLEN-1:0] addend_p1;
  logic [VLEN-1:0] old_p1;
  logic [NB-1:0]   act_p1;
  logic            neg_p1;
  sew_e            sew_p1;
  logic            vld_p1, ill_p1;
  logic            vld_p2, ill_p2;
  logic            vld_p3, ill_p3;
  logic [VLEN-1:0] lane_out;

  assign sew_in = sew_e'(bus.sew);
  assign legal  = (sew_bits(sew_in) != 6'd0);

  // Every stage moves together; a full output stage blocks the whole pipe.
  assign adv             = !vld_p3 || bus.out_ready;
  assign bus.in_ready    = adv;
  assign bus.out_valid   = vld_p3;
  assign bus.out_illegal = ill_p3;
  assign bus.out_data    = lane_out;

  // Replicate the scalar across every element for the .vx forms.
  always_comb begin
    bcast = '0;
    case (sew_in)
      SEW8:    bcast = {NB{bus.scalar_rs1[7:0]}};
      SEW16:   bcast = {(VLEN/16){bus.scalar_rs1[15:0]}};
      SEW32:   bcast = {NL{bus.scalar_rs1}};
      default: bcast = '0;
    endcase
  end

  // Multiplier operands and addend; old vd is always data_C.
  always_comb begin
    mul_a_in  = bus.accum_op[0] ? bcast : bus.data_A;
    mul_b_in  = bus.accum_op[2] ? bus.data_C : bus.data_B;
    addend_in = bus.accum_op[2] ? bus.data_B : bus.data_C;
  end

  // Per-byte active flags. An element index never reaches VLMAX, so
  // comparing it with the raw vl already clamps vl to VLMAX.
  always_comb begin
    act8   = '0;
    act16  = '0;
    act32  = '0;
    act_in = '0;
    for (int b = 0; b < NB; b++) begin
      act8[b]  = VL_W'(b)     < bus.vl;
      act16[b] = VL_W'(b / 2) < bus.vl;
      act32[b] = VL_W'(b / 4) < bus.vl;
`ifdef VMAC_MASK_EN
      act8[b]  = act8[b]  && (bus.vm || bus.mask_v0[b]);
      act16[b] = act16[b] && (bus.vm || bus.mask_v0[b / 2]);
      act32[b] = act32[b] && (bus.vm || bus.mask_v0[b / 4]);
`endif
    end
    case (sew_in)
      SEW8:    act_in = act8;
      SEW16:   act_in = act16;
      SEW32:   act_in = act32;
      default: act_in = '0;
    endcase
  end

  // ---- S1: stage valid/illegal flags and their S2/S3 successors ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      ill_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ill_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      ill_p3 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= bus.in_valid;
      ill_p1 <= bus.in_valid && !legal;
      vld_p2 <= vld_p1;
      ill_p2 <= ill_p1;
      vld_p3 <= vld_p2;
      ill_p3 <= ill_p2;
    end
  end

  // ---- S1: capture selected operands on the accepting edge ----
  always_ff @(posedge clk) begin
    if (adv && bus.in_valid) begin
      mul_a_p1  <= mul_a_in;
      mul_b_p1  <= mul_b_in;
      addend_p1 <= addend_in;
      old_p1    <= bus.data_C;
      act_p1    <= act_in;
      neg_p1    <= bus.accum_op[1];
      sew_p1    <= sew_in;
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane
    vmac_lane u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (adv),
      .sew      (sew_p1),
      .mul_a    (mul_a_p1[32*l +: 32]),
      .mul_b    (mul_b_p1[32*l +: 32]),
      .addend   (addend_p1[32*l +: 32]),
      .old_vd   (old_p1[32*l +: 32]),
      .byte_act (act_p1[4*l +: 4]),
      .neg      (neg_p1),
      .result   (lane_out[32*l +: 32])
    );
  end

endmodule

// File: tb/tb_vector_mac_pipeline.sv
// Bench for vector_mac_pipeline: directed cases, backpressure, reset and a
// randomized run against an element-level reference model.
module tb_vector_mac_pipeline;
  import vmac_pkg::*;

  localparam int VLEN = 128;
  localparam int VL_W = $clog2(VLEN/8) + 1;
  localparam int NB   = VLEN / 8;
  localparam int NL   = VLEN / 32;

  typedef struct {
    logic [VLEN-1:0] data;
    logic            ill;
    int              cyc;
  } rec_t;

  typedef struct {
    logic [2:0]      op;
    logic [1:0]      sw;
    logic [VL_W-1:0] vl;
    logic [VLEN-1:0] a, b, c;
    logic [31:0]     rs1;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  rec_t exp_q[$];
  rec_t got_q[$];

  vector_mac_pipeline_if #(.VLEN(VLEN), .VL_W(VL_W)) bus ();

`ifdef VMAC_MASK_EN
  logic          cur_vm = 1'b1;
  logic [NB-1:0] cur_mask = '1;
  assign bus.vm      = cur_vm;
  assign bus.mask_v0 = cur_mask;
`endif

  vector_mac_pipeline #(.VLEN(VLEN), .VL_W(VL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Element-level reference: vd_i = +/-(x*y)+z mod 2^SEW on active elements.
  function automatic rec_t model(input logic [2:0] op, input logic [1:0] sw,
                                 input logic [VL_W-1:0] vl, input logic [VLEN-1:0] a,
                                 input logic [31:0] rs1, input logic [VLEN-1:0] b,
                                 input logic [VLEN-1:0] c, input logic vm,
                                 input logic [NB-1:0] m, input int t);
    rec_t r;
    int w, n;
    longint unsigned mk, ea, eb, ec, x, z, p, v;
    r.data = c;
    r.ill  = (sw == 2'b11);
    r.cyc  = t;
    if (!r.ill) begin
      w  = 8 << sw;
      n  = VLEN / w;
      mk = (64'd1 << w) - 64'd1;
      for (int i = 0; i < n; i++) begin
        ea = (op[0] ? 64'(rs1) : 64'(a >> (i*w))) & mk;
        eb = 64'(b >> (i*w)) & mk;
        ec = 64'(c >> (i*w)) & mk;
        x  = op[2] ? ec : eb;
        z  = op[2] ? eb : ec;
        p  = (ea * x) & mk;
        v  = (op[1] ? z - p : z + p) & mk;
        if (i < int'(vl) && (vm || m[i]))
          for (int j = 0; j < w; j++) r.data[i*w + j] = v[j];
      end
    end
    return r;
  endfunction

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] r;
    for (int k = 0; k < NL; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic op_t rand_op(input bit legal_only);
    op_t o;
    o.op  = 3'($urandom_range(0, 7));
    o.sw  = 2'($urandom_range(0, legal_only ? 2 : 3));
    o.vl  = VL_W'($urandom_range(0, (1 << VL_W) - 1));
    o.a   = rand_vec();
    o.b   = rand_vec();
    o.c   = rand_vec();
    o.rs1 = $urandom;
    return o;
  endfunction

  // Record accepted operations (with model result) and delivered results.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.accum_op, bus.sew, bus.vl, bus.data_A, bus.scalar_rs1,
                              bus.data_B, bus.data_C,
`ifdef VMAC_MASK_EN
                              cur_vm, cur_mask,
`else
                              1'b1, '1,
`endif
                              cyc));
      if (bus.out_valid && bus.out_ready)
        got_q.push_back('{data: bus.out_data, ill: bus.out_illegal, cyc: cyc});
    end
  end

  task automatic set_op(input op_t o);
    bus.accum_op   = o.op;
    bus.sew        = o.sw;
    bus.vl         = o.vl;
    bus.data_A     = o.a;
    bus.data_B     = o.b;
    bus.data_C     = o.c;
    bus.scalar_rs1 = o.rs1;
  endtask

  task automatic send_one();
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end
  endtask

  task automatic wait_out(input int n);
    for (int k = 0; k < 300; k++) begin
      if (got_q.size() >= n) break;
      @(posedge clk); #1;
    end
    if (got_q.size() < n) begin
      n_checks++;
      $display("FAIL wait_out results=%0d required=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_data !== '0) $display("FAIL rst_out_data got=%h exp=0", bus.out_data); else n_pass++;
    n_checks++; if (bus.out_illegal !== 1'b0) $display("FAIL rst_out_illegal got=%b exp=0", bus.out_illegal); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_vmacc_vv();
    op_t o;
    rec_t g, e;
    o = '{op: VMACC_VV, sw: 2'b00, vl: VL_W'(NB), a: {NB{8'h03}}, b: {NB{8'h03}},
          c: {NB{8'h01}}, rs1: $urandom};
    set_op(o); send_one(); wait_out(1);
    g = got_q.pop_front(); e = exp_q.pop_front();
    n_checks++; if (g.data !== {NB{8'h0A}}) $display("FAIL vmacc_vv_data got=%h exp=%h", g.data, {NB{8'h0A}}); else n_pass++;
    n_checks++; if (g.data !== e.data) $display("FAIL vmacc_vv_model got=%h exp=%h", g.data, e.data); else n_pass++;
    n_checks++; if (g.ill !== 1'b0) $display("FAIL vmacc_vv_illegal got=%b exp=0", g.ill); else n_pass++;
    n_checks++; if (g.cyc - e.cyc != 3) $display("FAIL vmacc_vv_latency got=%0d exp=3", g.cyc - e.cyc); else n_pass++;
  endtask

  task automatic test_vnmsub_vx();
    op_t o;
    rec_t g, e;
    o = '{op: VNMSUB_VX, sw: 2'b10, vl: VL_W'(NL), a: rand_vec(), b: {NL{32'h1}},
          c: {NL{32'h5}}, rs1: 32'h2};
    set_op(o); send_one(); wait_out(1);
    g = got_q.pop_front(); e = exp_q.pop_front();
    n_checks++; if (g.data !== {NL{32'hFFFFFFF7}}) $display("FAIL vnmsub_vx_data got=%h exp=%h", g.data, {NL{32'hFFFFFFF7}}); else n_pass++;
    n_checks++; if (g.data !== e.data) $display("FAIL vnmsub_vx_model got=%h exp=%h", g.data, e.data); else n_pass++;
    n_checks++; if (g.cyc - e.cyc != 3) $display("FAIL vnmsub_vx_latency got=%0d exp=3", g.cyc - e.cyc); else n_pass++;
  endtask

  task automatic test_vmadd_tail();
    op_t o;
    rec_t g, e;
    logic [VLEN-1:0] want;
    o = '{op: VMADD_VV, sw: 2'b01, vl: VL_W'(3), a: {(VLEN/16){16'h0100}},
          b: {(VLEN/16){16'h0001}}, c: {(VLEN/16){16'h0100}}, rs1: $urandom};
    want = {(VLEN/16){16'h0100}};
    want[47:0] = {3{16'h0001}};
    set_op(o); send_one(); wait_out(1);
    g = got_q.pop_front(); e = exp_q.pop_front();
    n_checks++; if (g.data !== want) $display("FAIL vmadd_tail_data got=%h exp=%h", g.data, want); else n_pass++;
    n_checks++; if (g.data !== e.data) $display("FAIL vmadd_tail_model got=%h exp=%h", g.data, e.data); else n_pass++;
  endtask

`ifdef VMAC_MASK_EN
  task automatic test_mask();
    op_t o;
    rec_t g, e;
    o = '{op: VNMSAC_VV, sw: 2'b00, vl: VL_W'(NB), a: {NB{8'h02}}, b: {NB{8'h02}},
          c: {NB{8'h10}}, rs1: $urandom};
    cur_vm   = 1'b0;
    cur_mask = {(NB/2){2'b01}};
    set_op(o); send_one(); wait_out(1);
    cur_vm   = 1'b1;
    cur_mask = '1;
    g = got_q.pop_front(); e = exp_q.pop_front();
    n_checks++; if (g.data !== {(NB/2){16'h100C}}) $display("FAIL mask_data got=%h exp=%h", g.data, {(NB/2){16'h100C}}); else n_pass++;
    n_checks++; if (g.data !== e.data) $display("FAIL mask_model got=%h exp=%h", g.data, e.data); else n_pass++;
  endtask
`endif

  task automatic test_illegal();
    op_t o;
    rec_t g;
    o = rand_op(1'b0);
    o.sw = 2'b11;
    set_op(o); send_one(); wait_out(1);
    g = got_q.pop_front(); void'(exp_q.pop_front());
    n_checks++; if (g.ill !== 1'b1) $display("FAIL illegal_flag got=%b exp=1", g.ill); else n_pass++;
    n_checks++; if (g.data !== o.c) $display("FAIL illegal_data got=%h exp=%h", g.data, o.c); else n_pass++;
  endtask

  task automatic test_vl_edges();
    logic [VL_W-1:0] vls[4];
    op_t o;
    rec_t g, e;
    vls = '{VL_W'(0), VL_W'(NL), VL_W'(NL + 1), VL_W'((1 << VL_W) - 1)};
    for (int i = 0; i < 4; i++) begin
      o = rand_op(1'b1);
      o.sw = 2'b10;
      o.vl = vls[i];
      set_op(o); send_one(); wait_out(1);
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (g.data !== e.data) $display("FAIL vl_edge_%0d got=%h exp=%h", vls[i], g.data, e.data); else n_pass++;
      if (i == 0) begin
        n_checks++; if (g.data !== o.c) $display("FAIL vl_zero_data got=%h exp=%h", g.data, o.c); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[4];
    logic [11:0] obs;
    int sent = 0;
    rec_t g, e;
    for (int i = 0; i < 4; i++) ops[i] = rand_op(1'b1);
    for (int k = 0; k < 12; k++) begin
      bus.out_ready = !(k >= 3 && k <= 5);
      if (sent < 4) begin set_op(ops[sent]); bus.in_valid = 1'b1; end
      else bus.in_valid = 1'b0;
      @(negedge clk);
      obs[k] = bus.in_ready;
      if ((k == 4 || k == 5) && exp_q.size() > 0) begin
        n_checks++;
        if (bus.out_data !== exp_q[0].data) $display("FAIL stall_hold_k%0d got=%h exp=%h", k, bus.out_data, exp_q[0].data);
        else n_pass++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_checks++; if (obs !== 12'b1111_1100_0111) $display("FAIL b2b_in_ready got=%b exp=%b", obs, 12'b1111_1100_0111); else n_pass++;
    wait_out(4);
    repeat (5) begin @(posedge clk); #1; end
    n_checks++; if (got_q.size() != 4) $display("FAIL b2b_count got=%0d exp=4", got_q.size()); else n_pass++;
    for (int i = 0; i < 4 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if ({g.ill, g.data} !== {e.ill, e.data}) $display("FAIL b2b_result_%0d got=%h exp=%h", i, g.data, e.data); else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int n_ops = 60;
    rec_t g, e;
    fork
      begin
        for (int i = 0; i < n_ops; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
`ifdef VMAC_MASK_EN
          cur_vm   = 1'($urandom_range(0, 1));
          cur_mask = NB'($urandom);
`endif
          set_op(rand_op(1'b0));
          send_one();
        end
      end
      begin
        for (int k = 0; k < 400; k++) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_out(n_ops);
    for (int i = 0; i < n_ops && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({g.ill, g.data} !== {e.ill, e.data}) $display("FAIL random_%0d got=%b/%h exp=%b/%h", i, g.ill, g.data, e.ill, e.data);
      else n_pass++;
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    int seen = 0;
    bus.out_ready = 1'b1;
    set_op(rand_op(1'b1)); send_one();
    set_op(rand_op(1'b1)); send_one();
    reset = 1'b1;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL inflight_rst_out_valid got=%b exp=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL inflight_rst_in_ready got=%b exp=1", bus.in_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    n_checks++; if (seen != 0) $display("FAIL inflight_outputs got=%0d exp=0", seen); else n_pass++;
    n_checks++; if (got_q.size() != 0) $display("FAIL inflight_results got=%0d exp=0", got_q.size()); else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.accum_op   = '0;
    bus.sew        = '0;
    bus.vl         = '0;
    bus.data_A     = '0;
    bus.data_B     = '0;
    bus.data_C     = '0;
    bus.scalar_rs1 = '0;
    test_reset();
    test_vmacc_vv();
    test_vnmsub_vx();
    test_vmadd_tail();
`ifdef VMAC_MASK_EN
    test_mask();
`endif
    test_illegal();
    test_vl_edges();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vector_mac_pipeline.md
# vector_mac_pipeline

Pipelined, parametrised vector integer multiply-add engine for the vector execution stage. It executes the eight RVV single-width multiply-add forms (vmacc, vnmsac, vmadd, vnmsub; .vv and .vx) across a VLEN-bit register group at SEW 8/16/32. It adds true scalar broadcast, vl-based tail handling, optional v0 masking and a valid/ready handshake with backpressure. It sustains one operation per cycle and replaces the single-shot multiply-add path between the operand read stage and vector writeback.

## Interface
Parameters:
- VLEN, 512, datapath width in bits; multiple of 32, at least 32.
- VL_W, $clog2(VLEN/8)+1, width of the vl port.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- accum_op  in  3  [2]=0: vd=±(A·B)+C; [2]=1: vd=±(A·C)+B; [1]=1 negates product; [0]=1 .vx form.
- sew  in  2  00=8, 01=16, 10=32; 11 illegal.
- vl  in  VL_W  active element count.
- data_A  in  VLEN  vs1.
- scalar_rs1  in  32  rs1; low SEW bits used when accum_op[0]=1.
- data_B  in  VLEN  vs2.
- data_C  in  VLEN  old vd.
- vm  in  1  1 = unmasked (only with VMAC_MASK_EN).
- mask_v0  in  VLEN/8  v0 bits, one per element index (only with VMAC_MASK_EN).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_data  out  VLEN  new vd.
- out_illegal  out  1  result carries an illegal-sew flag.

## Operation
- Element i occupies bits [i·SEW +: SEW]. VLMAX = VLEN/SEW.
- For .vx ops, A is replaced in every element by scalar_rs1[SEW-1:0].
- Product is the low SEW bits of the element product. Signed and unsigned give identical low bits, so no sign mode exists. The add and negate use two's complement modulo 2^SEW with no saturation.
- An element is active when i < min(vl, VLMAX) and (vm=1 or mask_v0[i]=1).
- Inactive elements (tail or masked-off) output data_C unchanged (undisturbed policy). This applies to all ops, because old vd is always data_C.
- vl=0: out_data = data_C. vl > VLMAX clamps to VLMAX.
- sew=11: operation flows through the pipeline, out_data = data_C, out_illegal=1.
- Pipeline stages:
  - S1 registers the selected operands, broadcast scalar, addend, old vd, active-element vector and negate flag.
  - S2 registers the lane products.
  - S3 registers negate+add merged with old vd into out_data.

## Timing
- Reset: out_valid=0, out_data=0, out_illegal=0, all stage valid bits 0. in_ready is 1 during and after reset.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- While adv=0, every stage holds contents. Bubbles are not compressed.
- Latency: an operation accepted in cycle n gives out_valid in cycle n+3 when adv stays 1. Throughput is 1 op/cycle.
- out_data and out_illegal are stable while out_valid && !out_ready.
- Simultaneous accept and output handshake in the same cycle is legal and loses nothing.
- Reset asserted mid-operation discards all in-flight operations immediately. No output is produced for them.
- Inputs are sampled only on the accepting edge. Changes while in_ready=0 are ignored.

## Configuration
- VMAC_MASK_EN defined: vm and mask_v0 ports exist, and masking applies as above.
- VMAC_MASK_EN undefined: those ports are absent, every element below vl is active, and no mask logic is generated.

## Structure
- Package vmac_pkg holds:
  - accum_op_e, with the eight ops VMACC_VV..VNMSUB_VX at encodings 000..111.
  - sew_e (SEW8, SEW16, SEW32, SEW_ILLEGAL).
  - Helper function sew_bits.
- Sub-module vmac_lane: one 32-bit lane with registered S2/S3 internals. It takes sew, a per-byte active mask and negate, and does 4×8 / 2×16 / 1×32 multiply-low plus add/merge. It is instantiated VLEN/32 times.
- The top level holds operand select, broadcast, active-mask generation, the handshake and the stage valid bits.

## Test plan
- VMACC_VV, sew=00, vl=VLMAX, A=B=all 0x03, C=all 0x01 -> out_data all 0x0A at cycle n+3.
- VNMSUB_VX, sew=10, rs1=0x00000002, C=all 0x00000005, B=all 0x00000001 -> every element 0xFFFFFFF7.
- VMADD_VV, sew=01, vl=3, A=C=all 0x0100, B=all 0x0001 -> elements 0..2 = 0x0001 (overflow wraps); elements ≥3 = 0x0100.
- With VMAC_MASK_EN: VNMSAC_VV, sew=00, vm=0, mask_v0=0x…55, A=B=0x02, C=0x10 -> even elements 0x0C, odd elements 0x10.
- Back-to-back 4 ops with out_ready low for cycles 3–5 -> in_ready low exactly those cycles, results in order, none dropped or duplicated.
- sew=11 -> out_illegal=1, out_data=data_C. Reset during 2 in-flight ops -> out_valid stays 0 afterward.
